// File: rtl/sized_array_fifo.sv
// -----------------------------------------------------------------------------
// sized_array_fifo
//
// Synchronous FIFO built on a size-declared unpacked storage array. DEPTH need
// not be a power of two: both pointers wrap explicitly from DEPTH-1 back to 0,
// and occupancy is tracked by a separate counter rather than derived from the
// pointers.
//
// Handshake: a word moves only on a rising clock edge where its valid and
// ready are both high. push = in_valid && in_ready, pop = out_valid &&
// out_ready. in_ready and out_valid depend only on registered state, never on
// in_valid or out_ready, so there is no combinational path from either input
// handshake to an output handshake.
//
// Parameters:
//   WIDTH  data word width (1..64)
//   DEPTH  number of storage entries (2..16)
//   AFULL  almost_full threshold (1..DEPTH)
//
// Ports:
//   clock        rising-edge clock for all state
//   reset        synchronous active-high reset; wins over flush, push and pop
//   flush        synchronous clear of pointers/count; wins over push and pop
//   in_valid     producer offers in_data
//   in_ready     FIFO can accept a word this cycle (count < DEPTH)
//   in_data      write data
//   out_valid    out_data holds the oldest stored word (count > 0)
//   out_ready    consumer takes out_data this cycle
//   out_data     oldest stored word, all-zero while out_valid is low
//   count        number of stored words
//   almost_full  count >= AFULL
// -----------------------------------------------------------------------------
module sized_array_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int AFULL = DEPTH - 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    // Storage is never reset; out_data is masked whenever the FIFO is empty,
    // so unwritten entries can never reach an output.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_rd_next;

    assign in_ready    = (r_count < DEPTH_C);
    assign out_valid   = (r_count != '0);
    assign almost_full = (r_count >= AFULL_C);
    assign count       = r_count;
    assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Explicit wrap keeps non-power-of-two depths from indexing past DEPTH-1.
    assign w_wr_next = (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next = (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_sized_array_fifo.sv
// -----------------------------------------------------------------------------
// tb_sized_array_fifo
//
// Directed scenarios followed by a randomized phase. The reference model is
// an occupancy number plus a queue of words in push order; a separate monitor
// compares DUT outputs against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_sized_array_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int AFULL = DEPTH - 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clock;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             almost_full;

    sized_array_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AFULL(AFULL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .almost_full(almost_full)
    );

    // ---------------------------------------------------------------- clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------------------------------------------------------- scoreboard
    logic [WIDTH-1:0] exp_q[$];
    int               m_count = 0;
    int               n_vec   = 0;
    int               n_err   = 0;
    bit               mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is accepted whenever fewer than DEPTH are held,
    // a word leaves whenever at least one is held and the consumer is ready.
    always @(posedge clock) begin
        int p;
        int q;
        if (reset || flush) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            p = (in_valid && (m_count < DEPTH)) ? 1 : 0;
            q = (out_ready && (m_count > 0)) ? 1 : 0;
            if (p == 1) exp_q.push_back(in_data);
            m_count = m_count + p - q;
        end
    end

    // Monitor: compares every output against the model; pops the expected
    // queue whenever the DUT presents a word the consumer is taking.
    always @(negedge clock) begin
        logic [WIDTH-1:0] exp_d;
        if (mon_en) begin
            check("count", 32'(count), 32'(m_count));
            check("in_ready", 32'(in_ready), 32'(m_count < DEPTH));
            check("out_valid", 32'(out_valid), 32'(m_count > 0));
            check("almost_full", 32'(almost_full), 32'(m_count >= AFULL));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_data_underflow: got %0h expected no word at %0t", out_data, $time);
                end else if (out_ready) begin
                    exp_d = exp_q.pop_front();
                    check("out_data_pop", 32'(out_data), 32'(exp_d));
                end else begin
                    check("out_data_peek", 32'(out_data), 32'(exp_q[0]));
                end
            end else begin
                check("out_data_zero", 32'(out_data), 32'h0);
            end
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r,
                         input logic f, input logic rst);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        reset     = rst;
    endtask

    task automatic push_n(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + WIDTH'(i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [WIDTH-1:0] seq [3];
        seq[0] = 8'h11;
        seq[1] = 8'h22;
        seq[2] = 8'h33;

        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle();
        mon_en = 1'b1;
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);

        // One-cycle latency, no fall-through
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("lat_same_cycle_valid", 32'(out_valid), 32'd0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("lat_next_valid", 32'(out_valid), 32'd1);
        check("lat_next_data", 32'(out_data), 32'hA5);
        pop_n(1);

        // Fill to full, then drain in order
        push_n(3, 8'h11);
        push_n(0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h11 + WIDTH'(i * 8'h11), 1'b0, 1'b0, 1'b0);
            if (i == 0) begin
                // push_n above already filled with 0x11,0x12,0x13; redo cleanly
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        pop_n(3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd3);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_almost_full", 32'(almost_full), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("drain_order", 32'(out_data), 32'(seq[i]));
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("drained_out_valid", 32'(out_valid), 32'd0);
        check("drained_out_data", 32'(out_data), 32'd0);

        // Streaming with one word resident; pointers wrap several times
        push_n(1, 8'h40);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, WIDTH'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
            cycle();
            check("stream_count", 32'(count), 32'd1);
        end
        pop_n(1);

        // Full with both handshakes high: pop only, then push accepted
        push_n(3, 8'h60);
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("full_both_in_ready", 32'(in_ready), 32'd0);
        cycle();
        check("full_both_count", 32'(count), 32'd2);
        check("full_both_in_ready_next", 32'(in_ready), 32'd1);
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("refill_count", 32'(count), 32'd3);
        pop_n(3);

        // Flush overrides push and pop
        push_n(2, 8'h80);
        drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-operation discards contents
        push_n(2, 8'hC0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("midrst_count", 32'(count), 32'd0);
        push_n(1, 8'h5A);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("midrst_first_pop", 32'(out_data), 32'h5A);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
            cycle();
        end

        // Drain and confirm nothing was left unaccounted for
        pop_n(DEPTH + 1);
        cycle();
        check("final_count", 32'(count), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
